led_anim_seq: RTL and testbench

//  Parametrised LED animation sequencer for multiplexed 7-segment displays.

---
 rtl/led_anim_pkg.sv | 33 +++
 rtl/led_anim_rom.sv | 36 +++
 rtl/led_anim_seq.sv | 200 ++++++++++++++++++++
 tb/tb_led_anim_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/led_anim_pkg.sv
// Shared definitions for the LED animation sequencer: mode and FSM state
// encodings, the blank segment value and the default pattern table.
package led_anim_pkg;

  // Animation modes as presented on the mode input.
  typedef enum logic [1:0] {
    MODE_LOOP     = 2'd0,
    MODE_PINGPONG = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_STEP     = 2'd3
  } mode_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Internal patterns are active-high {g,f,e,d,c,b,a}; this is "all off".
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Default pattern table entry for (digit, frame): frame 0 is blank on every
  // digit, other frames light one segment that rotates with frame and digit,
  // so digit 0 frame 3 lights segment g (7'h40).
  function automatic logic [6:0] default_pattern(input int unsigned digit,
                                                 input int unsigned frame);
    if (frame == 0) return SEG_BLANK;
    return 7'(32'd1 << ((frame + digit + 32'd3) % 32'd7));
  endfunction

endpackage

// File: rtl/led_anim_rom.sv
// Combinational pattern lookup: (digit, frame) -> 7-bit active-high pattern.
// Ports:
//   digit    in  DIG_W    scan digit index
//   frame    in  FRAME_W  animation frame index
//   pattern  out 7        segments {g,f,e,d,c,b,a}, active-high
module led_anim_rom
  import led_anim_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned N_FRAMES = 32,
  parameter int unsigned DIG_W    = 2,
  parameter int unsigned FRAME_W  = 5
) (
  input  logic [DIG_W-1:0]   digit,
  input  logic [FRAME_W-1:0] frame,
  output logic [6:0]         pattern
);

  logic [6:0] rom_table [N_DIGITS][N_FRAMES];

  // Table contents are elaboration-time constants.
  for (genvar d = 0; d < int'(N_DIGITS); d++) begin : g_dig
    for (genvar f = 0; f < int'(N_FRAMES); f++) begin : g_frm
      assign rom_table[d][f] = default_pattern(d, f);
    end
  end

  // Out-of-range indices (non power-of-two sizes) read as blank.
  always_comb begin
    pattern = SEG_BLANK;
    if (32'(digit) < N_DIGITS && 32'(frame) < N_FRAMES) begin
      pattern = rom_table[digit][frame];
    end
  end

endmodule

// File: rtl/led_anim_seq.sv
// LED animation sequencer for multiplexed 7-segment displays. Steps a frame
// index through the pattern table in loop, ping-pong, one-shot or manual-step
// mode and time-multiplexes N_DIGITS digits onto one segment bus.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      pulse: restart at frame 0 going up, latch mode
//   stop       pulse: go idle and blank the display
//   pause      level: freeze frame advance (scan keeps running)
//   step       pulse: advance one frame in step mode
//   mode       animation mode, sampled on start
//   tick_div   frame period = tick_div+1 clocks
//   seg, dig   registered segment bus and one-hot digit enable
//   frame_idx  current frame
//   busy       high while running or paused
//   done       one-cycle pulse when one-shot reaches the last frame
module led_anim_seq
  import led_anim_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned N_FRAMES    = 32,
  parameter int unsigned FRAME_W     = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
  parameter int unsigned DIV_W       = 24,
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned SEG_ACT_LOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                step,
  input  logic [1:0]          mode,
  input  logic [DIV_W-1:0]    tick_div,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] dig,
  output logic [FRAME_W-1:0]  frame_idx,
  output logic                busy,
  output logic                done
);

  localparam int unsigned DIG_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(N_FRAMES - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(N_DIGITS - 1);
  // XOR masks that convert internal active-high values to pin polarity.
  localparam logic [6:0]          SEG_POL = {7{SEG_ACT_LOW != 0}};
  localparam logic [N_DIGITS-1:0] DIG_POL = {N_DIGITS{SEG_ACT_LOW != 0}};

  state_e               state, state_next;
  mode_e                mode_q, mode_next;
  logic [FRAME_W-1:0]   frame_next;
  logic                 dir_down, dir_next;
  logic [DIV_W-1:0]     presc, presc_next;
  logic                 done_next;
  logic                 advance;
  logic [SCAN_W-1:0]    scan_cnt;
  logic [DIG_W-1:0]     scan_idx;
  logic [6:0]           pattern;
  logic [N_DIGITS-1:0]  dig_onehot;

  // FSM and frame datapath register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_LOOP;
      frame_idx <= '0;
      dir_down  <= 1'b0;
      presc     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      mode_q    <= mode_next;
      frame_idx <= frame_next;
      dir_down  <= dir_next;
      presc     <= presc_next;
      busy      <= (state_next == ST_RUN) || (state_next == ST_PAUSE);
      done      <= done_next;
    end
  end

  // Next state, prescaler and frame advance; priority stop > start > pause > advance.
  always_comb begin
    state_next = state;
    mode_next  = mode_q;
    frame_next = frame_idx;
    dir_next   = dir_down;
    presc_next = presc;
    done_next  = 1'b0;
    advance    = 1'b0;

    if (stop) begin
      state_next = ST_IDLE;
      frame_next = '0;
      dir_next   = 1'b0;
      presc_next = '0;
    end else if (start) begin
      state_next = ST_RUN;
      mode_next  = mode_e'(mode);
      frame_next = '0;
      dir_next   = 1'b0;
      presc_next = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (pause) begin
            state_next = ST_PAUSE;
          end else if (mode_q == MODE_STEP) begin
            advance = step;
          end else if (presc >= tick_div) begin
            // '>=' so a tick_div lowered below the count still fires.
            presc_next = '0;
            advance    = 1'b1;
          end else begin
            presc_next = presc + DIV_W'(1);
          end
        end
        ST_PAUSE: if (!pause) state_next = ST_RUN;
        default: ;
      endcase
    end

    if (advance) begin
      case (mode_q)
        MODE_PINGPONG: begin
          // Reverse on the end frame itself so it is shown only once.
          if (LAST_FRAME == '0) begin
            frame_next = '0;
          end else if (!dir_down) begin
            if (frame_idx == LAST_FRAME) begin
              dir_next   = 1'b1;
              frame_next = frame_idx - FRAME_W'(1);
            end else begin
              frame_next = frame_idx + FRAME_W'(1);
            end
          end else begin
            if (frame_idx == '0) begin
              dir_next   = 1'b0;
              frame_next = frame_idx + FRAME_W'(1);
            end else begin
              frame_next = frame_idx - FRAME_W'(1);
            end
          end
        end
        MODE_ONESHOT: begin
          // done coincides with the last frame appearing on frame_idx.
          if (frame_idx == LAST_FRAME || frame_idx == LAST_FRAME - FRAME_W'(1)) begin
            frame_next = LAST_FRAME;
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            frame_next = frame_idx + FRAME_W'(1);
          end
        end
        default: begin
          frame_next = (frame_idx == LAST_FRAME) ? '0 : frame_idx + FRAME_W'(1);
        end
      endcase
    end
  end

  // Digit scan: held at digit 0 while idle.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == DIG_LAST) ? '0 : scan_idx + DIG_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  led_anim_rom #(
    .N_DIGITS (N_DIGITS),
    .N_FRAMES (N_FRAMES),
    .DIG_W    (DIG_W),
    .FRAME_W  (FRAME_W)
  ) u_rom (
    .digit   (scan_idx),
    .frame   (frame_idx),
    .pattern (pattern)
  );

  assign dig_onehot = N_DIGITS'(1) << scan_idx;

  // seg and dig share one register so they always switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      seg <= SEG_BLANK ^ SEG_POL;
      dig <= DIG_POL;
    end else begin
      seg <= pattern ^ SEG_POL;
      dig <= dig_onehot ^ DIG_POL;
    end
  end

endmodule

// File: tb/tb_led_anim_seq.sv
// Directed bench for led_anim_seq: 4 digits, 4 frames, scan every 2 clocks,
// active-low pins. Inputs change and outputs are sampled on the falling edge.
module tb_led_anim_seq;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, step;
  logic [1:0] mode;
  logic [7:0] tick_div;
  logic [6:0] seg;
  logic [3:0] dig;
  logic [1:0] frame_idx;
  logic       busy, done;

  int errors = 0;
  int checks = 0;

  // Expected dig/seg after each clock of a fresh LOOP run with tick_div=0.
  logic [3:0] scan_dig [5] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB};
  logic [6:0] scan_seg [5] = '{7'h7F, 7'h6F, 7'h3F, 7'h7E, 7'h7F};
  logic [1:0] pp_seq   [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};

  led_anim_seq #(
    .N_DIGITS    (4),
    .N_FRAMES    (4),
    .DIV_W       (8),
    .SCAN_DIV    (2),
    .SEG_ACT_LOW (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .step      (step),
    .mode      (mode),
    .tick_div  (tick_div),
    .seg       (seg),
    .dig       (dig),
    .frame_idx (frame_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stop for one clock (clears scan phase), then start in the given mode.
  task automatic go(input logic [1:0] m, input logic [7:0] td);
    stop = 1'b1;
    clk_n(1);
    stop     = 1'b0;
    mode     = m;
    tick_div = td;
    start    = 1'b1;
    clk_n(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; step = 1'b0;
    mode = 2'd0; tick_div = 8'd2;
    clk_n(3);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dig", 32'(dig), 32'hF);
    check("reset_frame", 32'(frame_idx), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    clk_n(1);

    // LOOP, tick_div=2: frame advances every 3 clocks and wraps.
    go(2'd0, 8'd2);
    check("loop_frame0", 32'(frame_idx), 32'd0);
    check("loop_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      clk_n(2);
      check($sformatf("loop_hold%0d", k), 32'(frame_idx), 32'((k - 1) % 4));
      clk_n(1);
      check($sformatf("loop_adv%0d", k), 32'(frame_idx), 32'(k % 4));
    end

    // Reset in the middle of a run.
    rst = 1'b1;
    clk_n(1);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_dig", 32'(dig), 32'hF);
    check("midrst_frame", 32'(frame_idx), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    clk_n(1);

    // Scan rotation and one-clock output latency.
    go(2'd0, 8'd0);
    check("scan_seg_idle", 32'(seg), 32'h7F);
    check("scan_dig_idle", 32'(dig), 32'hF);
    check("scan_frame0", 32'(frame_idx), 32'd0);
    for (int i = 0; i < 5; i++) begin
      clk_n(1);
      check($sformatf("scan_dig%0d", i), 32'(dig), 32'(scan_dig[i]));
      check($sformatf("scan_seg%0d", i), 32'(seg), 32'(scan_seg[i]));
    end

    // PINGPONG, tick_div=0: end frames not repeated.
    go(2'd1, 8'd0);
    check("pp_frame0", 32'(frame_idx), 32'd0);
    for (int i = 0; i < 7; i++) begin
      clk_n(1);
      check($sformatf("pp_frame%0d", i + 1), 32'(frame_idx), 32'(pp_seq[i]));
    end

    // ONESHOT: single done pulse with frame 3, then hold.
    go(2'd2, 8'd0);
    check("os_frame0", 32'(frame_idx), 32'd0);
    check("os_done0", 32'(done), 32'd0);
    clk_n(1);
    check("os_frame1", 32'(frame_idx), 32'd1);
    check("os_done1", 32'(done), 32'd0);
    clk_n(1);
    check("os_frame2", 32'(frame_idx), 32'd2);
    check("os_done2", 32'(done), 32'd0);
    clk_n(1);
    check("os_frame3", 32'(frame_idx), 32'd3);
    check("os_done_pulse", 32'(done), 32'd1);
    check("os_busy_done", 32'(busy), 32'd0);
    clk_n(1);
    check("os_frame_hold", 32'(frame_idx), 32'd3);
    check("os_done_low", 32'(done), 32'd0);
    check("os_busy_low", 32'(busy), 32'd0);
    clk_n(4);
    check("os_dig3", 32'(dig), 32'h7);
    check("os_seg_d3f3", 32'(seg), 32'h7B);
    clk_n(1);
    check("os_dig0", 32'(dig), 32'hE);
    check("os_seg_d0f3", 32'(seg), 32'h3F);
    check("os_frame_held", 32'(frame_idx), 32'd3);
    start = 1'b1;
    clk_n(1);
    start = 1'b0;
    check("os_restart_frame", 32'(frame_idx), 32'd0);
    check("os_restart_busy", 32'(busy), 32'd1);

    // Pause freezes the frame while the scan keeps rotating.
    go(2'd0, 8'd0);
    clk_n(1);
    check("pause_pre_frame", 32'(frame_idx), 32'd1);
    pause = 1'b1;
    clk_n(1);
    check("pause_frame_a", 32'(frame_idx), 32'd1);
    check("pause_busy", 32'(busy), 32'd1);
    check("pause_dig_a", 32'(dig), 32'hE);
    clk_n(1);
    check("pause_frame_b", 32'(frame_idx), 32'd1);
    check("pause_dig_b", 32'(dig), 32'hD);
    check("pause_seg_b", 32'(seg), 32'h5F);
    clk_n(2);
    check("pause_frame_c", 32'(frame_idx), 32'd1);
    check("pause_dig_c", 32'(dig), 32'hB);
    check("pause_seg_c", 32'(seg), 32'h3F);
    start = 1'b1;
    stop  = 1'b1;
    clk_n(1);
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    check("prio_busy", 32'(busy), 32'd0);
    check("prio_frame", 32'(frame_idx), 32'd0);
    clk_n(1);
    check("prio_seg_blank", 32'(seg), 32'h7F);
    check("prio_dig_blank", 32'(dig), 32'hF);

    // STEP: frame moves only on step pulses and wraps.
    go(2'd3, 8'd0);
    clk_n(3);
    check("step_idle_frame", 32'(frame_idx), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step = 1'b1;
      clk_n(1);
      step = 1'b0;
      check($sformatf("step_frame%0d", k), 32'(frame_idx), 32'(k % 4));
    end
    clk_n(2);
    check("step_hold", 32'(frame_idx), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
